// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: 3-5 cycles per instruction plus memory wait cycles.
// Memory states stall on mem_ready and fall into ERROR after TIMEOUT_CYCLES waits (0 = never).
module mips_multicycle_ctrl #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mdr_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_ctrl,
    output logic [1:0] pc_src,
    output logic       instr_done,
    output logic       illegal_op,
    output logic       bus_error,
    output logic [3:0] dbg_state
);
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LIM = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
        S_MEMWB   = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
        S_BRANCH  = 4'd8,  S_ADDIEX = 4'd9,  S_ADDIWB = 4'd10, S_JUMP   = 4'd11,
        S_ILLEGAL = 4'd12, S_ERROR  = 4'd13
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [CW-1:0] wait_cnt;
    logic          mem_wait;
    logic          timeout;
    logic          r_legal;
    logic [2:0]    r_alu;

    always_comb begin
        r_legal = 1'b1;
        r_alu   = 3'b010;
        case (funct)
            6'h20:   r_alu = 3'b010;
            6'h22:   r_alu = 3'b110;
            6'h24:   r_alu = 3'b000;
            6'h25:   r_alu = 3'b001;
            6'h2A:   r_alu = 3'b111;
            default: r_legal = 1'b0;
        endcase
    end

    assign mem_wait = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
    // The limit cycle still accepts mem_ready; only a miss on it times out.
    assign timeout  = mem_wait && !mem_ready && (TIMEOUT_CYCLES != 0) && (wait_cnt == LIM);

    always_comb begin
        next_state = state;
        case (state)
            S_FETCH:  if (mem_ready) next_state = S_DECODE; else if (timeout) next_state = S_ERROR;
            S_DECODE: begin
                case (opcode)
                    6'h00:        next_state = r_legal ? S_EXEC : S_ILLEGAL;
                    6'h23, 6'h2B: next_state = S_MEMADR;
                    6'h04:        next_state = S_BRANCH;
                    6'h08:        next_state = S_ADDIEX;
                    6'h02:        next_state = S_JUMP;
                    default:      next_state = S_ILLEGAL;
                endcase
            end
            S_MEMADR: next_state = opcode[3] ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) next_state = S_MEMWB; else if (timeout) next_state = S_ERROR;
            S_MEMWR:  if (mem_ready) next_state = S_FETCH; else if (timeout) next_state = S_ERROR;
            S_EXEC:   next_state = S_ALUWB;
            S_ADDIEX: next_state = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: next_state = S_FETCH;
            S_ILLEGAL, S_ERROR: next_state = state;
            default:  next_state = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
        end else begin
            state <= next_state;
            if (next_state != state || mem_ready)
                wait_cnt <= '0;
            else if (mem_wait)
                wait_cnt <= wait_cnt + CW'(1);
        end
    end

    always_comb begin
        pc_en = 1'b0; iord = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        ir_write = 1'b0; mdr_write = 1'b0; reg_dst = 1'b0; mem_to_reg = 1'b0;
        reg_write = 1'b0; alu_src_a = 1'b0; alu_src_b = 2'b00; alu_ctrl = 3'b010;
        pc_src = 2'b00; instr_done = 1'b0; illegal_op = 1'b0; bus_error = 1'b0;
        case (state)
            S_FETCH:  begin mem_read = 1'b1; alu_src_b = 2'b01;
                            ir_write = mem_ready; pc_en = mem_ready; end
            S_DECODE: alu_src_b = 2'b11;
            S_MEMADR: begin alu_src_a = 1'b1; alu_src_b = 2'b10; end
            S_MEMRD:  begin mem_read = 1'b1; iord = 1'b1; mdr_write = mem_ready; end
            S_MEMWB:  begin reg_write = 1'b1; mem_to_reg = 1'b1; instr_done = 1'b1; end
            S_MEMWR:  begin mem_write = 1'b1; iord = 1'b1; instr_done = mem_ready; end
            S_EXEC:   begin alu_src_a = 1'b1; alu_ctrl = r_alu; end
            S_ALUWB:  begin reg_write = 1'b1; reg_dst = 1'b1; instr_done = 1'b1; end
            S_BRANCH: begin alu_src_a = 1'b1; alu_ctrl = 3'b110; pc_src = 2'b01;
                            pc_en = zero; instr_done = 1'b1; end
            S_ADDIEX: begin alu_src_a = 1'b1; alu_src_b = 2'b10; end
            S_ADDIWB: begin reg_write = 1'b1; instr_done = 1'b1; end
            S_JUMP:   begin pc_src = 2'b10; pc_en = 1'b1; instr_done = 1'b1; end
            S_ILLEGAL: illegal_op = 1'b1;
            S_ERROR:   bus_error = 1'b1;
            default: ;
        endcase
        // Reset cycle suppresses every strobe, even mid memory access.
        if (rst) begin
            pc_en = 1'b0; iord = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
            ir_write = 1'b0; mdr_write = 1'b0; reg_dst = 1'b0; mem_to_reg = 1'b0;
            reg_write = 1'b0; alu_src_a = 1'b0; alu_src_b = 2'b00; alu_ctrl = 3'b010;
            pc_src = 2'b00; instr_done = 1'b0; illegal_op = 1'b0; bus_error = 1'b0;
        end
    end

    assign dbg_state = state;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench: two controller instances (timeout 4 and timeout disabled) share stimulus.
module tb_mips_multicycle_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode, funct;
    logic       zero, mem_ready;

    logic pc_en, iord, mem_read, mem_write, ir_write, mdr_write, reg_dst, mem_to_reg;
    logic reg_write, alu_src_a, instr_done, illegal_op, bus_error;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_ctrl;
    logic [3:0] dbg_state;

    logic nt_pc_en, nt_iord, nt_mem_read, nt_mem_write, nt_ir_write, nt_mdr_write, nt_reg_dst;
    logic nt_mem_to_reg, nt_reg_write, nt_alu_src_a, nt_instr_done, nt_illegal_op, nt_bus_error;
    logic [1:0] nt_alu_src_b, nt_pc_src;
    logic [2:0] nt_alu_ctrl;
    logic [3:0] nt_dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mips_multicycle_ctrl #(.TIMEOUT_CYCLES(4)) u_dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_en(pc_en), .iord(iord), .mem_read(mem_read),
        .mem_write(mem_write), .ir_write(ir_write), .mdr_write(mdr_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl),
        .pc_src(pc_src), .instr_done(instr_done), .illegal_op(illegal_op),
        .bus_error(bus_error), .dbg_state(dbg_state)
    );

    mips_multicycle_ctrl #(.TIMEOUT_CYCLES(0)) u_dut_nt (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_en(nt_pc_en), .iord(nt_iord), .mem_read(nt_mem_read),
        .mem_write(nt_mem_write), .ir_write(nt_ir_write), .mdr_write(nt_mdr_write),
        .reg_dst(nt_reg_dst), .mem_to_reg(nt_mem_to_reg), .reg_write(nt_reg_write),
        .alu_src_a(nt_alu_src_a), .alu_src_b(nt_alu_src_b), .alu_ctrl(nt_alu_ctrl),
        .pc_src(nt_pc_src), .instr_done(nt_instr_done), .illegal_op(nt_illegal_op),
        .bus_error(nt_bus_error), .dbg_state(nt_dbg_state)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // New inputs at the falling edge; outputs sampled 1 ns later for the current state.
    task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic z, input logic rdy);
        @(negedge clk);
        rst = 1'b0; opcode = op; funct = fn; zero = z; mem_ready = rdy;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; mem_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("rst.state", dbg_state, 0);
        chk("rst.mem_read", mem_read, 0);
        chk("rst.ir_write", ir_write, 0);
        chk("rst.src_b", alu_src_b, 0);
        chk("rst.alu", alu_ctrl, 3'b010);
        chk("rst.flags", {illegal_op, bus_error}, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
        do_reset();

        // R-type add, mem_ready high: 0,1,6,7
        drive(6'h00, 6'h20, 0, 1);
        chk("radd.f.state", dbg_state, 0);
        chk("radd.f.ir_pc", {ir_write, pc_en, mem_read, iord}, 4'b1110);
        chk("radd.f.src_b", alu_src_b, 2'b01);
        drive(6'h00, 6'h20, 0, 1);
        chk("radd.d.state", dbg_state, 1);
        chk("radd.d.src_b", alu_src_b, 2'b11);
        drive(6'h00, 6'h20, 0, 1);
        chk("radd.e.state", dbg_state, 6);
        chk("radd.e.alu", alu_ctrl, 3'b010);
        chk("radd.e.src", {alu_src_a, alu_src_b}, 3'b100);
        drive(6'h00, 6'h20, 0, 1);
        chk("radd.wb.state", dbg_state, 7);
        chk("radd.wb.ctl", {reg_write, reg_dst, mem_to_reg, instr_done}, 4'b1101);
        drive(6'h00, 6'h22, 0, 1);
        chk("radd.next.state", dbg_state, 0);

        // R-type sub continues straight on
        drive(6'h00, 6'h22, 0, 1);
        drive(6'h00, 6'h22, 0, 1);
        chk("rsub.e.alu", alu_ctrl, 3'b110);
        drive(6'h00, 6'h22, 0, 1);

        // lw with three wait cycles in MEMRD: 8 cycles total
        drive(6'h23, 6'h00, 0, 1);
        chk("lw.f.state", dbg_state, 0);
        drive(6'h23, 6'h00, 0, 1);
        chk("lw.d.state", dbg_state, 1);
        drive(6'h23, 6'h00, 0, 0);
        chk("lw.a.state", dbg_state, 2);
        chk("lw.a.src", {alu_src_a, alu_src_b}, 3'b110);
        for (int i = 0; i < 3; i++) begin
            drive(6'h23, 6'h00, 0, 0);
            chk("lw.wait.state", dbg_state, 3);
            chk("lw.wait.rd_iord_mdr", {mem_read, iord, mdr_write}, 3'b110);
        end
        drive(6'h23, 6'h00, 0, 1);
        chk("lw.rdy.rd_iord_mdr", {mem_read, iord, mdr_write}, 3'b111);
        drive(6'h23, 6'h00, 0, 1);
        chk("lw.wb.state", dbg_state, 4);
        chk("lw.wb.ctl", {reg_write, reg_dst, mem_to_reg, instr_done}, 4'b1011);
        drive(6'h2B, 6'h00, 0, 1);
        chk("lw.next.state", dbg_state, 0);

        // sw, 4 cycles
        drive(6'h2B, 6'h00, 0, 1);
        drive(6'h2B, 6'h00, 0, 1);
        drive(6'h2B, 6'h00, 0, 1);
        chk("sw.wr.state", dbg_state, 5);
        chk("sw.wr.ctl", {mem_write, mem_read, iord, reg_write, instr_done}, 5'b10101);

        // beq taken then not taken, 3 cycles each
        drive(6'h04, 6'h00, 1, 1);
        chk("beq1.f.state", dbg_state, 0);
        drive(6'h04, 6'h00, 1, 1);
        drive(6'h04, 6'h00, 1, 1);
        chk("beq1.b.state", dbg_state, 8);
        chk("beq1.b.ctl", {pc_en, pc_src, alu_ctrl, instr_done}, 7'b1_01_110_1);
        drive(6'h04, 6'h00, 0, 1);
        drive(6'h04, 6'h00, 0, 1);
        drive(6'h04, 6'h00, 0, 1);
        chk("beq0.b.state", dbg_state, 8);
        chk("beq0.b.pc_en", {pc_en, instr_done}, 2'b01);

        // addi 0,1,9,10 then j 0,1,11
        drive(6'h08, 6'h00, 0, 1);
        drive(6'h08, 6'h00, 0, 1);
        drive(6'h08, 6'h00, 0, 1);
        chk("addi.ex.state", dbg_state, 9);
        chk("addi.ex.src", {alu_src_a, alu_src_b}, 3'b110);
        drive(6'h08, 6'h00, 0, 1);
        chk("addi.wb.ctl", {dbg_state, reg_write, reg_dst, mem_to_reg, instr_done}, 8'hA9);
        drive(6'h02, 6'h00, 0, 1);
        drive(6'h02, 6'h00, 0, 1);
        drive(6'h02, 6'h00, 0, 1);
        chk("j.state", dbg_state, 11);
        chk("j.ctl", {pc_en, pc_src, instr_done}, 4'b1101);

        // Illegal opcode: sticky until reset
        drive(6'h3F, 6'h00, 0, 1);
        drive(6'h3F, 6'h00, 0, 1);
        drive(6'h3F, 6'h00, 0, 1);
        chk("ill.state", dbg_state, 12);
        chk("ill.flag", illegal_op, 1);
        for (int i = 0; i < 3; i++) drive(6'h00, 6'h20, 0, 1);
        chk("ill.hold.state", dbg_state, 12);
        chk("ill.hold.strobes", {mem_read, mem_write, ir_write, pc_en, reg_write}, 0);
        do_reset();

        // R-type with funct 00h is illegal
        drive(6'h00, 6'h00, 0, 1);
        drive(6'h00, 6'h00, 0, 1);
        drive(6'h00, 6'h00, 0, 1);
        chk("illf.state", dbg_state, 12);
        chk("illf.flag", illegal_op, 1);
        do_reset();

        // Fetch timeout with limit 4; the no-timeout instance keeps waiting
        for (int i = 0; i < 4; i++) begin
            drive(6'h00, 6'h20, 0, 0);
            chk("to.wait.state", dbg_state, 0);
            chk("to.wait.ir_write", {ir_write, pc_en}, 0);
        end
        drive(6'h00, 6'h20, 0, 0);
        chk("to.err.state", dbg_state, 13);
        chk("to.err.flag", bus_error, 1);
        chk("to.err.strobes", {mem_read, ir_write}, 0);
        for (int i = 0; i < 20; i++) drive(6'h00, 6'h20, 0, 0);
        chk("nt.wait.state", nt_dbg_state, 0);
        chk("nt.wait.flag", nt_bus_error, 0);
        drive(6'h00, 6'h20, 0, 1);
        chk("nt.rdy.ir_write", nt_ir_write, 1);
        chk("to.err.hold", {dbg_state, bus_error}, 8'h1B);

        // Reset during a MEMWR wait
        do_reset();
        drive(6'h2B, 6'h00, 0, 1);
        drive(6'h2B, 6'h00, 0, 1);
        drive(6'h2B, 6'h00, 0, 0);
        drive(6'h2B, 6'h00, 0, 0);
        chk("swrst.wait.ctl", {dbg_state, mem_write, instr_done}, 8'h16);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("swrst.rst.strobes", {mem_write, instr_done, iord}, 0);
        drive(6'h2B, 6'h00, 0, 0);
        chk("swrst.after.state", dbg_state, 0);
        chk("swrst.after.ctl", {mem_read, mem_write, bus_error, illegal_op}, 4'b1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
